// File: rtl/arp_pkg.sv
// Shared ARP constants, state encoding and payload types for the ARP receive sequencer.
package arp_pkg;

  localparam int unsigned OPER_W = 16;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned IP_W   = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OPER_W-1:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [OPER_W-1:0] ARP_OPER_REPLY   = 16'd2;
  localparam logic [MAC_W-1:0]  ETH_BROADCAST    = 48'hFFFF_FFFF_FFFF;
  localparam logic [CNT_W-1:0]  CNT_MAX          = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CACHE_WR,
    ST_TX_REPLY,
    ST_TX_REQUEST
  } arp_state_e;

  typedef enum logic {
    GRANT_REQ   = 1'b0,
    GRANT_FRAME = 1'b1
  } arp_grant_e;

  typedef struct packed {
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
  } cache_wr_t;

  typedef struct packed {
    logic [OPER_W-1:0] oper;
    logic [MAC_W-1:0]  dest_mac;
    logic [MAC_W-1:0]  tha;
    logic [IP_W-1:0]   tpa;
  } tx_frame_t;

  function automatic logic oper_supported(input logic [OPER_W-1:0] oper);
    return (oper == ARP_OPER_REQUEST) || (oper == ARP_OPER_REPLY);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import arp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/arp_rx_ctrl.sv
// ARP receive sequencer: filters decoded frames, writes cache bindings, and shares
// the transmit path round-robin between replies and locally requested resolutions.
module arp_rx_ctrl
  import arp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              s_frame_valid,
  output logic              s_frame_ready,
  input  logic [OPER_W-1:0] s_arp_oper,
  input  logic [MAC_W-1:0]  s_arp_sha,
  input  logic [IP_W-1:0]   s_arp_spa,
  input  logic              s_ip_matched,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IP_W-1:0]   req_ip,

  output logic              m_cache_wr_valid,
  input  logic              m_cache_wr_ready,
  output logic [IP_W-1:0]   m_cache_wr_ip,
  output logic [MAC_W-1:0]  m_cache_wr_mac,

  output logic              m_tx_valid,
  input  logic              m_tx_ready,
  output logic [OPER_W-1:0] m_tx_oper,
  output logic [MAC_W-1:0]  m_tx_eth_dest_mac,
  output logic [MAC_W-1:0]  m_tx_tha,
  output logic [IP_W-1:0]   m_tx_tpa,

  output logic [CNT_W-1:0]  stat_reply_count,
  output logic [CNT_W-1:0]  stat_drop_count,
  output logic              busy
);

  arp_state_e state_q, state_d;
  arp_grant_e last_grant_q, last_grant_d;

  cache_wr_t  cache_q, cache_d;
  logic       cache_valid_q, cache_valid_d;
  tx_frame_t  tx_q, tx_d;
  logic       tx_valid_q, tx_valid_d;
  logic       is_request_q, is_request_d;
  logic       busy_q;

  logic       grant_frame;
  logic       grant_req;
  logic       reply_inc;
  logic       drop_inc;

  // Round-robin grant: on a tie the source not served last wins.
  always_comb begin
    grant_frame = 1'b0;
    grant_req   = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_frame = s_frame_valid && (!req_valid || (last_grant_q == GRANT_REQ));
      grant_req   = req_valid && (!s_frame_valid || (last_grant_q == GRANT_FRAME));
    end
  end

  assign s_frame_ready = grant_frame;
  assign req_ready     = grant_req;

  // Next-state and next-output logic; outputs are registered from the *_d values.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cache_d       = cache_q;
    cache_valid_d = cache_valid_q;
    tx_d          = tx_q;
    tx_valid_d    = tx_valid_q;
    is_request_d  = is_request_q;
    reply_inc     = 1'b0;
    drop_inc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_frame) begin
          last_grant_d = GRANT_FRAME;
          if (s_ip_matched && oper_supported(s_arp_oper)) begin
            cache_d.ip    = s_arp_spa;
            cache_d.mac   = s_arp_sha;
            cache_valid_d = 1'b1;
            is_request_d  = (s_arp_oper == ARP_OPER_REQUEST);
            state_d       = ST_CACHE_WR;
          end else begin
            drop_inc = 1'b1;
          end
        end else if (grant_req) begin
          last_grant_d    = GRANT_REQ;
          tx_d.oper       = ARP_OPER_REQUEST;
          tx_d.dest_mac   = ETH_BROADCAST;
          tx_d.tha        = '0;
          tx_d.tpa        = req_ip;
          tx_valid_d      = 1'b1;
          state_d         = ST_TX_REQUEST;
        end
      end

      ST_CACHE_WR: begin
        if (m_cache_wr_ready) begin
          cache_valid_d = 1'b0;
          if (is_request_q) begin
            tx_d.oper     = ARP_OPER_REPLY;
            tx_d.dest_mac = cache_q.mac;
            tx_d.tha      = cache_q.mac;
            tx_d.tpa      = cache_q.ip;
            tx_valid_d    = 1'b1;
            state_d       = ST_TX_REPLY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_TX_REPLY: begin
        if (m_tx_ready) begin
          tx_valid_d = 1'b0;
          reply_inc  = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_TX_REQUEST: begin
        if (m_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_REQ;
      cache_q       <= '0;
      cache_valid_q <= 1'b0;
      tx_q          <= '0;
      tx_valid_q    <= 1'b0;
      is_request_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cache_q       <= cache_d;
      cache_valid_q <= cache_valid_d;
      tx_q          <= tx_d;
      tx_valid_q    <= tx_valid_d;
      is_request_q  <= is_request_d;
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  sat_counter16 u_reply_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (reply_inc),
    .count (stat_reply_count)
  );

  sat_counter16 u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (stat_drop_count)
  );

  assign m_cache_wr_valid  = cache_valid_q;
  assign m_cache_wr_ip     = cache_q.ip;
  assign m_cache_wr_mac    = cache_q.mac;
  assign m_tx_valid        = tx_valid_q;
  assign m_tx_oper         = tx_q.oper;
  assign m_tx_eth_dest_mac = tx_q.dest_mac;
  assign m_tx_tha          = tx_q.tha;
  assign m_tx_tpa          = tx_q.tpa;
  assign busy              = busy_q;

endmodule

// File: tb/tb_arp_rx_ctrl.sv
// Bench for arp_rx_ctrl: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a queue-of-pending-actions model.
module tb_arp_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_frame_valid, s_frame_ready;
  logic [15:0] s_arp_oper;
  logic [47:0] s_arp_sha;
  logic [31:0] s_arp_spa;
  logic        s_ip_matched;
  logic        req_valid, req_ready;
  logic [31:0] req_ip;
  logic        m_cache_wr_valid, m_cache_wr_ready;
  logic [31:0] m_cache_wr_ip;
  logic [47:0] m_cache_wr_mac;
  logic        m_tx_valid, m_tx_ready;
  logic [15:0] m_tx_oper;
  logic [47:0] m_tx_eth_dest_mac, m_tx_tha;
  logic [31:0] m_tx_tpa;
  logic [15:0] stat_reply_count, stat_drop_count;
  logic        busy;

  always #5 clk = ~clk;

  arp_rx_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .s_frame_valid     (s_frame_valid),
    .s_frame_ready     (s_frame_ready),
    .s_arp_oper        (s_arp_oper),
    .s_arp_sha         (s_arp_sha),
    .s_arp_spa         (s_arp_spa),
    .s_ip_matched      (s_ip_matched),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_ip            (req_ip),
    .m_cache_wr_valid  (m_cache_wr_valid),
    .m_cache_wr_ready  (m_cache_wr_ready),
    .m_cache_wr_ip     (m_cache_wr_ip),
    .m_cache_wr_mac    (m_cache_wr_mac),
    .m_tx_valid        (m_tx_valid),
    .m_tx_ready        (m_tx_ready),
    .m_tx_oper         (m_tx_oper),
    .m_tx_eth_dest_mac (m_tx_eth_dest_mac),
    .m_tx_tha          (m_tx_tha),
    .m_tx_tpa          (m_tx_tpa),
    .stat_reply_count  (stat_reply_count),
    .stat_drop_count   (stat_drop_count),
    .busy              (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the ordered list of output actions the block still owes.
  typedef struct {
    bit          is_tx;
    logic [15:0] oper;
    logic [47:0] dest, tha, mac;
    logic [31:0] ip;
  } act_t;

  act_t        q[$];
  logic [15:0] m_reply, m_drop;
  bit          m_last_req;
  bit          frame_taken, req_taken;
  bit          cmp_en = 0;
  bit          log_en = 0;
  bit          grant_log[$];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic bit exp_frame_ready();
    return (q.size() == 0) && s_frame_valid && (!req_valid || m_last_req);
  endfunction

  function automatic bit exp_req_ready();
    return (q.size() == 0) && req_valid && (!s_frame_valid || !m_last_req);
  endfunction

  always @(posedge clk) begin
    act_t a;
    bit gf, gr;
    frame_taken = 0;
    req_taken   = 0;
    if (rst) begin
      q.delete();
      m_reply    = 16'd0;
      m_drop     = 16'd0;
      m_last_req = 1;
    end else begin
      gf = exp_frame_ready();
      gr = exp_req_ready();
      frame_taken = gf;
      req_taken   = gr;
      if (q.size() > 0) begin
        if (!q[0].is_tx && m_cache_wr_ready) begin
          void'(q.pop_front());
        end else if (q[0].is_tx && m_tx_ready) begin
          if (q[0].oper == 16'd2) m_reply = sat_inc(m_reply);
          void'(q.pop_front());
        end
      end else if (gf) begin
        m_last_req = 0;
        if (s_ip_matched && (s_arp_oper == 16'd1 || s_arp_oper == 16'd2)) begin
          a = '{is_tx: 0, oper: 16'd0, dest: 48'd0, tha: 48'd0, mac: s_arp_sha, ip: s_arp_spa};
          q.push_back(a);
          if (s_arp_oper == 16'd1) begin
            a = '{is_tx: 1, oper: 16'd2, dest: s_arp_sha, tha: s_arp_sha, mac: 48'd0, ip: s_arp_spa};
            q.push_back(a);
          end
        end else begin
          m_drop = sat_inc(m_drop);
        end
      end else if (gr) begin
        m_last_req = 1;
        a = '{is_tx: 1, oper: 16'd1, dest: 48'hFFFF_FFFF_FFFF, tha: 48'd0, mac: 48'd0, ip: req_ip};
        q.push_back(a);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(busy), 64'(q.size() != 0));
      check("s_frame_ready", 64'(s_frame_ready), 64'(exp_frame_ready()));
      check("req_ready", 64'(req_ready), 64'(exp_req_ready()));
      check("cache_valid", 64'(m_cache_wr_valid), 64'(q.size() > 0 && !q[0].is_tx));
      check("tx_valid", 64'(m_tx_valid), 64'(q.size() > 0 && q[0].is_tx));
      if (q.size() > 0 && !q[0].is_tx) begin
        check("cache_ip", 64'(m_cache_wr_ip), 64'(q[0].ip));
        check("cache_mac", 64'(m_cache_wr_mac), 64'(q[0].mac));
      end
      if (q.size() > 0 && q[0].is_tx) begin
        check("tx_oper", 64'(m_tx_oper), 64'(q[0].oper));
        check("tx_dest", 64'(m_tx_eth_dest_mac), 64'(q[0].dest));
        check("tx_tha", 64'(m_tx_tha), 64'(q[0].tha));
        check("tx_tpa", 64'(m_tx_tpa), 64'(q[0].ip));
      end
      check("reply_count", 64'(stat_reply_count), 64'(m_reply));
      check("drop_count", 64'(stat_drop_count), 64'(m_drop));
    end
    if (log_en) begin
      if (s_frame_valid && s_frame_ready) grant_log.push_back(1'b0);
      if (req_valid && req_ready) grant_log.push_back(1'b1);
      if (m_tx_valid && m_tx_oper == 16'd1) begin
        check("arb_req_dest", 64'(m_tx_eth_dest_mac), 64'h0000_FFFF_FFFF_FFFF);
        check("arb_req_tha", 64'(m_tx_tha), 64'd0);
        check("arb_req_tpa", 64'(m_tx_tpa), 64'h0A00_0001);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents one frame and returns in the cycle right after it was accepted.
  task automatic send_frame(input logic [15:0] oper, input logic [47:0] sha,
                            input logic [31:0] spa, input logic matched);
    int n = 0;
    s_frame_valid = 1'b1;
    s_arp_oper    = oper;
    s_arp_sha     = sha;
    s_arp_spa     = spa;
    s_ip_matched  = matched;
    do begin
      tick();
      n++;
    end while (!frame_taken && n < 50);
    if (!frame_taken) check("frame_accept_timeout", 64'd0, 64'd1);
    s_frame_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [3:0] order;
    rst = 1'b1;
    s_frame_valid = 0; s_arp_oper = 0; s_arp_sha = 0; s_arp_spa = 0; s_ip_matched = 0;
    req_valid = 0; req_ip = 0;
    m_cache_wr_ready = 1; m_tx_ready = 1;
    tick();
    tick();
    rst = 1'b0;
    cmp_en = 1;

    // Reset state.
    check("rst_cache_valid", 64'(m_cache_wr_valid), 64'd0);
    check("rst_tx_valid", 64'(m_tx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx_tpa", 64'(m_tx_tpa), 64'd0);
    check("rst_cache_mac", 64'(m_cache_wr_mac), 64'd0);
    check("rst_counts", 64'({stat_reply_count, stat_drop_count}), 64'd0);
    req_valid = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    #1;

    // Request addressed to us.
    send_frame(16'd1, 48'h02_00_00_00_00_01, 32'hC0A8_010A, 1'b1);
    check("req_cache_valid", 64'(m_cache_wr_valid), 64'd1);
    check("req_cache_ip", 64'(m_cache_wr_ip), 64'hC0A8_010A);
    check("req_cache_mac", 64'(m_cache_wr_mac), 64'h0200_0000_0001);
    tick();
    check("reply_tx_valid", 64'(m_tx_valid), 64'd1);
    check("reply_oper", 64'(m_tx_oper), 64'd2);
    check("reply_dest", 64'(m_tx_eth_dest_mac), 64'h0200_0000_0001);
    check("reply_tha", 64'(m_tx_tha), 64'h0200_0000_0001);
    check("reply_tpa", 64'(m_tx_tpa), 64'hC0A8_010A);
    tick();
    check("reply_count_1", 64'(stat_reply_count), 64'd1);

    // Reply addressed to us: cache write only.
    send_frame(16'd2, 48'h02_00_00_00_00_22, 32'hC0A8_0114, 1'b1);
    check("rep_cache_valid", 64'(m_cache_wr_valid), 64'd1);
    tick();
    check("rep_no_tx", 64'(m_tx_valid), 64'd0);
    check("rep_reply_count", 64'(stat_reply_count), 64'd1);

    // Drops.
    send_frame(16'd1, 48'h02_00_00_00_00_33, 32'hC0A8_0115, 1'b0);
    check("drop1_no_cache", 64'(m_cache_wr_valid), 64'd0);
    check("drop1_count", 64'(stat_drop_count), 64'd1);
    send_frame(16'd3, 48'h02_00_00_00_00_44, 32'hC0A8_0116, 1'b1);
    check("drop2_count", 64'(stat_drop_count), 64'd2);

    // Arbitration right after reset: frame, request, frame, request.
    do_reset();
    log_en = 1;
    begin
      int f_left = 2;
      int r_left = 2;
      int n = 0;
      s_frame_valid = 1; s_arp_oper = 16'd2; s_arp_sha = 48'h02_00_00_00_00_55;
      s_arp_spa = 32'hC0A8_0117; s_ip_matched = 1;
      req_valid = 1; req_ip = 32'h0A00_0001;
      while ((f_left > 0 || r_left > 0) && n < 100) begin
        tick();
        n++;
        if (frame_taken) begin f_left--; if (f_left == 0) s_frame_valid = 0; end
        if (req_taken) begin r_left--; if (r_left == 0) req_valid = 0; end
      end
    end
    wait_idle();
    tick();
    log_en = 0;
    order = 4'hF;
    if (grant_log.size() == 4) order = {grant_log[3], grant_log[2], grant_log[1], grant_log[0]};
    check("arb_order", 64'(order), 64'b1010);

    // Back-pressure on the cache write.
    m_cache_wr_ready = 0;
    send_frame(16'd1, 48'h02_00_00_00_00_66, 32'hC0A8_0118, 1'b1);
    s_frame_valid = 1; s_arp_oper = 16'd2; s_arp_sha = 48'h02_00_00_00_00_77;
    s_arp_spa = 32'hC0A8_0119; s_ip_matched = 1;
    req_valid = 1; req_ip = 32'h0A00_0002;
    for (int i = 0; i < 10; i++) begin
      check("bp_cache_valid", 64'(m_cache_wr_valid), 64'd1);
      check("bp_cache_ip", 64'(m_cache_wr_ip), 64'hC0A8_0118);
      check("bp_cache_mac", 64'(m_cache_wr_mac), 64'h0200_0000_0066);
      check("bp_readies", 64'({s_frame_ready, req_ready}), 64'd0);
      tick();
    end
    m_cache_wr_ready = 1;
    begin
      int n = 0;
      while ((s_frame_valid || req_valid) && n < 100) begin
        tick();
        n++;
        if (frame_taken) s_frame_valid = 0;
        if (req_taken) req_valid = 0;
      end
      check("bp_drain_timeout", 64'({s_frame_valid, req_valid}), 64'd0);
    end
    wait_idle();

    // Reset while a reply is stalled.
    m_tx_ready = 0;
    send_frame(16'd1, 48'h02_00_00_00_00_88, 32'hC0A8_011A, 1'b1);
    tick();
    check("rst_mid_tx_valid_before", 64'(m_tx_valid), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    check("rst_mid_tx_valid", 64'(m_tx_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_counts", 64'({stat_reply_count, stat_drop_count}), 64'd0);
    m_tx_ready = 1;
    send_frame(16'd1, 48'h02_00_00_00_00_99, 32'hC0A8_011B, 1'b1);
    check("post_rst_cache_ip", 64'(m_cache_wr_ip), 64'hC0A8_011B);
    tick();
    tick();
    check("post_rst_reply_count", 64'(stat_reply_count), 64'd1);

    // Random traffic with random sink stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (frame_taken || !s_frame_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          s_frame_valid = 1;
          s_arp_oper    = 16'($urandom_range(0, 3));
          s_arp_sha     = {16'($urandom), 32'($urandom)};
          s_arp_spa     = 32'($urandom);
          s_ip_matched  = ($urandom_range(0, 3) != 0);
        end else begin
          s_frame_valid = 0;
        end
      end
      if (req_taken || !req_valid) begin
        req_valid = ($urandom_range(0, 3) == 0);
        req_ip    = 32'($urandom);
      end
      m_cache_wr_ready = ($urandom_range(0, 2) != 0);
      m_tx_ready       = ($urandom_range(0, 2) != 0);
    end
    rst = 0;
    s_frame_valid = 0;
    req_valid = 0;
    m_cache_wr_ready = 1;
    m_tx_ready = 1;
    wait_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arp_rx_ctrl.md
# arp_rx_ctrl

Sequencer sitting between the ARP frame receiver and the ARP frame transmitter/cache. Consumes decoded ARP frames, filters them against the local IP match flag, writes sender bindings into the ARP cache, and schedules reply frames. It shares the single ARP transmit path round-robin with locally generated ARP requests issued on cache misses.

## Interface
- No parameters; widths are fixed by the ARP/IPv4 header.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_frame_valid / s_frame_ready  in / out  1 / 1  decoded ARP frame handshake
- s_arp_oper  in  16  ARP operation
- s_arp_sha  in  48  sender hardware address
- s_arp_spa  in  32  sender protocol address
- s_ip_matched  in  1  target IP equals local IP; valid with s_frame_valid
- req_valid / req_ready  in / out  1 / 1  local ARP request handshake
- req_ip  in  32  IP address to resolve
- m_cache_wr_valid / m_cache_wr_ready  out / in  1 / 1  cache write handshake
- m_cache_wr_ip  out  32  cache write key
- m_cache_wr_mac  out  48  cache write value
- m_tx_valid / m_tx_ready  out / in  1 / 1  transmit frame handshake
- m_tx_oper  out  16  1 = request, 2 = reply
- m_tx_eth_dest_mac  out  48  Ethernet destination
- m_tx_tha  out  48  target hardware address
- m_tx_tpa  out  32  target protocol address
- stat_reply_count  out  16  replies sent, saturating
- stat_drop_count  out  16  frames dropped, saturating
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CACHE_WR, TX_REPLY, TX_REQUEST.
- IDLE: s_frame_ready = grant_frame, req_ready = grant_req. Both ready signals are combinational from the state and arbitration registers, and are only high in IDLE.
- Arbitration in IDLE:
  - Only one source valid: that source is granted.
  - Both valid: grant the source not served last. The last_grant bit resets to "request", so a frame wins the first tie.
- Frame accepted:
  - s_ip_matched = 0, or oper not 1 or 2: drop, increment stat_drop_count, stay in IDLE.
  - Otherwise capture sha/spa/oper and go to CACHE_WR.
- CACHE_WR: m_cache_wr_valid = 1 with {spa, sha}. When m_cache_wr_ready is seen, go to TX_REPLY if oper = 1, otherwise go to IDLE.
- TX_REPLY: m_tx_valid = 1, oper = 2, dest_mac = tha = captured sha, tpa = captured spa. When m_tx_ready is seen, increment stat_reply_count and go to IDLE.
- Request accepted: capture req_ip and go to TX_REQUEST.
- TX_REQUEST: m_tx_valid = 1, oper = 1, dest_mac = 48'hFFFFFFFFFFFF, tha = 0, tpa = captured req_ip. When m_tx_ready is seen, go to IDLE.
- Counters saturate at 16'hFFFF and never wrap.
- last_grant updates on every accepted frame (including dropped frames) and on every accepted request.

## Timing
- Reset values:
  - State = IDLE, last_grant = request.
  - All valid outputs = 0, all data outputs = 0, both counters = 0, busy = 0.
  - s_frame_ready = s_frame_valid and req_ready = req_valid, evaluated after reset under the IDLE arbitration rule.
- Latencies:
  - Accept to m_cache_wr_valid: 1 cycle.
  - Cache write handshake to m_tx_valid for a reply: 1 cycle.
  - Accept to m_tx_valid for a request: 1 cycle.
- Output valids are registered. Once asserted, a valid and its data hold stable until the matching ready is seen; there is no retraction.
- Minimum time from one frame accept to the next is 3 cycles for a request-oper frame with zero-wait sinks, and 1 cycle for a dropped frame.
- Inputs arriving while not in IDLE are back-pressured and are not lost.
- Rst asserted mid-operation returns to IDLE on the next edge and drops all valids. The pending cache write or transmit is abandoned, and counters clear.

## Structure
- Shared package `arp_pkg`:
  - ARP_OPER_REQUEST = 16'd1, ARP_OPER_REPLY = 16'd2, ETH_BROADCAST = 48'hFFFF_FFFF_FFFF.
  - State encoding enum.
- Single flat module. A small `sat_counter16` sub-module is natural, instantiated for both counters.

## Test plan
- Request to us: frame {oper = 1, sha = 02:00:00:00:00:01, spa = 192.168.1.10, matched = 1}, zero-wait sinks.
  - Cache write {C0A8010A, 020000000001} appears 1 cycle after accept.
  - Then a tx reply {oper 2, dest = tha = 020000000001, tpa = C0A8010A}.
  - stat_reply_count = 1.
- Reply to us: frame {oper = 2, matched = 1} -> cache write only, no m_tx_valid, stat_reply_count unchanged.
- Drops:
  - Frame with matched = 0 -> no outputs, stat_drop_count = 1.
  - Frame with oper = 3, matched = 1 -> stat_drop_count = 2.
- Arbitration: frame and req_ip = 10.0.0.1 valid in the same cycle right after reset, repeated twice back-to-back.
  - Grant order: frame, request, frame, request.
  - Each request transmit has oper = 1, dest = broadcast, tha = 0, tpa = 0A000001.
- Back-pressure: hold m_cache_wr_ready = 0 for 10 cycles.
  - m_cache_wr_valid stays high and its data is stable.
  - s_frame_ready = 0 and req_ready = 0 throughout.
  - Release ready -> sequence completes normally.
- Reset: rst for 1 cycle while in TX_REPLY with m_tx_ready = 0.
  - Next cycle m_tx_valid = 0, busy = 0, counters = 0.
  - A fresh frame is then accepted and processed normally.
